// File: rtl/npu_pkg.sv
// ---------------------------------------------------------------------------
// npu_pkg
// Shared definitions for the NPU feature-map read path.
//   ADDR_W_DEF / DATA_W_DEF / DIM_W_DEF : default RAM address, pixel and
//                                         window-dimension widths
//   rd_state_t                          : window reader sequencing states
// ---------------------------------------------------------------------------
package npu_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;
    localparam int DIM_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } rd_state_t;

endpackage

// File: rtl/conv_ram_reader_if.sv
// ---------------------------------------------------------------------------
// conv_ram_reader_if
// Bundles the feature-map RAM port and the outgoing pixel stream of the
// window reader.
//   ram_address / ram_data / ram_wren : RAM command side (reader drives)
//   ram_q                             : RAM read data, 1-cycle latency
//   out_valid / out_ready             : pixel stream handshake
//   out_data / out_eol / out_last     : pixel, end-of-row, end-of-window
// Modports: master = reader, slave = RAM + stream consumer.
// ---------------------------------------------------------------------------
interface conv_ram_reader_if
    import npu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_eol;
    logic              out_last;

    modport master (
        output ram_address, ram_data, ram_wren,
        input  ram_q,
        output out_valid, out_data, out_eol, out_last,
        input  out_ready
    );

    modport slave (
        input  ram_address, ram_data, ram_wren,
        output ram_q,
        input  out_valid, out_data, out_eol, out_last,
        output out_ready
    );

endinterface

// File: rtl/conv_rd_fifo.sv
// ---------------------------------------------------------------------------
// conv_rd_fifo
// Two-entry valid/ready FIFO that decouples captured RAM data from the
// stream consumer.
//   clock, reset_n : clock and asynchronous active-low reset
//   wr_valid       : push wr_data this cycle (caller guarantees not full)
//   wr_data        : entry to store
//   rd_ready       : consumer accepts the head entry
//   rd_valid       : head entry present
//   rd_data        : head entry (zero when empty)
//   count          : number of stored entries, 0..2
// ---------------------------------------------------------------------------
module conv_rd_fifo #(
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         wr_valid,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         push;
    logic         pop;

    assign push     = wr_valid;
    assign rd_valid = (count != 2'd0);
    assign pop      = rd_valid && rd_ready;
    // Mask the head so the stream outputs read zero while empty/after reset.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_ram_reader.sv
// ---------------------------------------------------------------------------
// conv_ram_reader
// Walks a rows x cols window of the feature-map RAM (row-major, programmable
// row stride, addresses wrap mod 2^ADDR_W) and streams the pixels out with
// end-of-row / end-of-window markers.
//   clock, reset_n        : clock and asynchronous active-low reset
//   start                 : one-cycle request, honoured only when idle
//   base_addr             : address of element (0,0)
//   num_rows / num_cols   : window size; either zero gives an empty window
//   row_stride            : address step between row starts
//   busy                  : window in progress
//   done                  : one-cycle completion pulse
//   bus (master)          : RAM port + pixel stream
// Reads are throttled so captured data plus the one read in flight never
// exceed the 2-entry output FIFO, which gives full rate under continuous
// ready and lossless backpressure.
// ---------------------------------------------------------------------------
module conv_ram_reader
    import npu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  num_rows,
    input  logic [DIM_W-1:0]  num_cols,
    input  logic [ADDR_W-1:0] row_stride,
    output logic              busy,
    output logic              done,
    conv_ram_reader_if.master bus
);

    rd_state_t         state;

    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] stride_l;
    logic [DIM_W-1:0]  col;
    logic [DIM_W-1:0]  row_idx;
    logic [DIM_W-1:0]  cols_l;
    logic [DIM_W-1:0]  rows_l;
    logic [ADDR_W-1:0] last_addr;

    logic              vld_p1;
    logic              eol_p1;
    logic              last_p1;

    logic              fifo_valid;
    logic [DATA_W+1:0] fifo_head;
    logic [1:0]        fifo_count;

    logic              accept;
    logic              pop;
    logic              issue;
    logic              col_end;
    logic              row_end;
    logic [1:0]        occupancy;
    logic [ADDR_W-1:0] issue_addr;

    // Issue stage (p0): decide whether a read goes out this cycle
    always_comb begin
        accept     = (state == ST_IDLE) && start && (num_rows != '0) && (num_cols != '0);
        col_end    = (col == cols_l - DIM_W'(1));
        row_end    = (row_idx == rows_l - DIM_W'(1));
        issue_addr = row_base + ADDR_W'(col);
        pop        = fifo_valid && bus.out_ready;
        occupancy  = fifo_count + {1'b0, vld_p1};
        // A slot frees up this cycle if the head pops, so a full pipeline
        // may still issue; this keeps one beat per cycle at steady state.
        issue      = (state == ST_RUN) &&
                     ((occupancy <= 2'd1) || ((occupancy == 2'd2) && pop));
    end

    assign bus.ram_address = issue ? issue_addr : last_addr;
    assign bus.ram_data    = '0;
    assign bus.ram_wren    = 1'b0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            vld_p1    <= 1'b0;
            last_addr <= '0;
        end else begin
            done   <= 1'b0;
            vld_p1 <= issue;
            if (issue) begin
                last_addr <= issue_addr;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end else if (start) begin
                        // Empty window: nothing to stream, just acknowledge.
                        done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (issue && col_end && row_end) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (pop && fifo_head[DATA_W]) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Address walk and marker delay (p0 -> p1); only meaningful while busy
    always_ff @(posedge clock) begin
        if (accept) begin
            row_base <= base_addr;
            stride_l <= row_stride;
            cols_l   <= num_cols;
            rows_l   <= num_rows;
            col      <= '0;
            row_idx  <= '0;
        end else if (issue) begin
            if (col_end) begin
                col      <= '0;
                row_base <= row_base + stride_l;
                row_idx  <= row_idx + DIM_W'(1);
            end else begin
                col <= col + DIM_W'(1);
            end
        end
        if (issue) begin
            eol_p1  <= col_end;
            last_p1 <= col_end && row_end;
        end
    end

    // Capture stage (p1): RAM data lands in the FIFO with its markers
    conv_rd_fifo #(
        .W (DATA_W + 2)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_valid (vld_p1),
        .wr_data  ({eol_p1, last_p1, bus.ram_q}),
        .rd_ready (bus.out_ready),
        .rd_valid (fifo_valid),
        .rd_data  (fifo_head),
        .count    (fifo_count)
    );

    assign bus.out_valid = fifo_valid;
    assign bus.out_data  = fifo_head[DATA_W-1:0];
    assign bus.out_last  = fifo_head[DATA_W];
    assign bus.out_eol   = fifo_head[DATA_W+1];

endmodule
